// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory pipeline stage.
package mem_stage_pkg;
    localparam int XLEN            = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; a bubble clears the control bits and holds the data.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  bubble_i,
    input  logic                  reg_write_i,
    input  logic                  mem_to_reg_i,
    input  logic [W-1:0]          read_data_i,
    input  logic [W-1:0]          alu_result_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  reg_write_o,
    output logic                  mem_to_reg_o,
    output logic [W-1:0]          read_data_o,
    output logic [W-1:0]          alu_result_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            reg_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
            read_data_o  <= '0;
            alu_result_o <= '0;
            rd_addr_o    <= '0;
        end else if (bubble_i) begin
            reg_write_o  <= 1'b0;
            mem_to_reg_o <= 1'b0;
        end else begin
            reg_write_o  <= reg_write_i;
            mem_to_reg_o <= mem_to_reg_i;
            read_data_o  <= read_data_i;
            alu_result_o <= alu_result_i;
            rd_addr_o    <= rd_addr_i;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: drives a multi-cycle data-memory handshake, stalls the front of
// the pipeline while an access is outstanding, and aborts on a dead memory.
module mem_access_unit
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = XLEN,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic                  Memory_write_i,
    input  logic                  Memory_read_i,
    input  logic [ADDR_W-1:0]     Data1_i,
    input  logic [ADDR_W-1:0]     mux7_output_data_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_i,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [ADDR_W-1:0]     mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [ADDR_W-1:0]     mem_rdata_i,
    output logic                  RegWrite_o,
    output logic                  MemtoReg_o,
    output logic [ADDR_W-1:0]     ReadData_o,
    output logic [ADDR_W-1:0]     ALUResult_o,
    output logic [REG_ADDR_W-1:0] RDaddr_o,
    output logic                  err_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] rbuf_q;
    logic [ADDR_W-1:0] wb_read_data;
    logic              access;
    logic              timeout_hit;

    assign access      = Memory_read_i | Memory_write_i;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Gated by reset so an aborted access releases the pipeline immediately.
    assign stall_o = rst_i & (((state_q == ST_IDLE) & access) | (state_q == ST_WAIT));

    // A finished access hands over the buffered load data; otherwise pass through.
    assign wb_read_data = (state_q == ST_DONE) ? rbuf_q : mem_rdata_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (access) state_d = ST_WAIT;
            ST_WAIT: if (mem_ack_i || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            cnt_q       <= '0;
            rbuf_q      <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= Memory_write_i;
                        mem_addr_o  <= Data1_i;
                        mem_wdata_o <= mux7_output_data_i;
                        cnt_q       <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        rbuf_q    <= mem_rdata_i;
                    end else if (timeout_hit) begin
                        mem_req_o <= 1'b0;
                        rbuf_q    <= '0;
                        err_o     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_wb_reg #(.W(ADDR_W)) u_mem_wb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bubble_i     (stall_o),
        .reg_write_i  (RegWrite_i),
        .mem_to_reg_i (MemtoReg_i),
        .read_data_i  (wb_read_data),
        .alu_result_i (Data1_i),
        .rd_addr_i    (RDaddr_i),
        .reg_write_o  (RegWrite_o),
        .mem_to_reg_o (MemtoReg_o),
        .read_data_o  (ReadData_o),
        .alu_result_o (ALUResult_o),
        .rd_addr_o    (RDaddr_o)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level expectation model.
module tb_mem_access_unit;

    localparam int          TO = 8;
    localparam logic [31:0] BG = 32'h5A5A_5A5A;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        RegWrite_i, MemtoReg_i, Memory_write_i, Memory_read_i;
    logic [31:0] Data1_i, mux7_output_data_i;
    logic [4:0]  RDaddr_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] ReadData_o, ALUResult_o;
    logic [4:0]  RDaddr_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .RegWrite_i         (RegWrite_i),
        .MemtoReg_i         (MemtoReg_i),
        .Memory_write_i     (Memory_write_i),
        .Memory_read_i      (Memory_read_i),
        .Data1_i            (Data1_i),
        .mux7_output_data_i (mux7_output_data_i),
        .RDaddr_i           (RDaddr_i),
        .stall_o            (stall_o),
        .mem_req_o          (mem_req_o),
        .mem_we_o           (mem_we_o),
        .mem_addr_o         (mem_addr_o),
        .mem_wdata_o        (mem_wdata_o),
        .mem_ack_i          (mem_ack_i),
        .mem_rdata_i        (mem_rdata_i),
        .RegWrite_o         (RegWrite_o),
        .MemtoReg_o         (MemtoReg_o),
        .ReadData_o         (ReadData_o),
        .ALUResult_o        (ALUResult_o),
        .RDaddr_o           (RDaddr_o),
        .err_o              (err_o)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int cyc = 0;
    int stall_total = 0;
    int req_rises = 0;
    int last_rise = 0;
    logic prev_req = 1'b0;
    int ack_tail = 0;

    // Expected outputs for the current cycle
    logic        e_stall, e_req, e_we, e_rw, e_m2r, e_err;
    logic [31:0] e_addr, e_wdata, e_rdata, e_alu;
    logic [4:0]  e_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("stall_o", {31'b0, stall_o}, {31'b0, e_stall});
            chk("mem_req_o", {31'b0, mem_req_o}, {31'b0, e_req});
            if (e_req) begin
                chk("mem_we_o", {31'b0, mem_we_o}, {31'b0, e_we});
                chk("mem_addr_o", mem_addr_o, e_addr);
                chk("mem_wdata_o", mem_wdata_o, e_wdata);
            end
            chk("RegWrite_o", {31'b0, RegWrite_o}, {31'b0, e_rw});
            chk("MemtoReg_o", {31'b0, MemtoReg_o}, {31'b0, e_m2r});
            chk("ReadData_o", ReadData_o, e_rdata);
            chk("ALUResult_o", ALUResult_o, e_alu);
            chk("RDaddr_o", {27'b0, RDaddr_o}, {27'b0, e_rd});
            chk("err_o", {31'b0, err_o}, {31'b0, e_err});
            if (stall_o) stall_total <= stall_total + 1;
            if (mem_req_o && !prev_req) begin
                req_rises <= req_rises + 1;
                last_rise <= cyc;
            end
        end
        prev_req <= mem_req_o;
    end

    // One clock edge: MEM/WB either bubbles or takes the presented instruction.
    task automatic edge_wb(input bit bubble, input logic [31:0] rd_val);
        @(posedge clk_i);
        if (bubble) begin
            e_rw  = 1'b0;
            e_m2r = 1'b0;
        end else begin
            e_rw    = RegWrite_i;
            e_m2r   = MemtoReg_i;
            e_alu   = Data1_i;
            e_rd    = RDaddr_i;
            e_rdata = rd_val;
        end
        #1;
    endtask

    // Present one instruction until it leaves the stage. k = ack latency after
    // the request rises (k >= TO means no ack), hold = cycles ack stays high.
    task automatic issue(input logic rw, m2r, mw, mr, input logic [31:0] a, wd,
                         input logic [4:0] rd, input int k, input int hold,
                         input logic [31:0] rdat);
        int nwait;
        bit to;
        RegWrite_i = rw; MemtoReg_i = m2r; Memory_write_i = mw; Memory_read_i = mr;
        Data1_i = a; mux7_output_data_i = wd; RDaddr_i = rd;
        mem_rdata_i = BG;
        if (!(mw | mr)) begin
            mem_ack_i = (ack_tail > 0);
            if (ack_tail > 0) ack_tail--;
            e_stall = 1'b0;
            edge_wb(1'b0, BG);
        end else begin
            to    = (k >= TO);
            nwait = to ? TO : k + 1;
            mem_ack_i = 1'b0;
            e_stall   = 1'b1;
            edge_wb(1'b1, 32'h0);
            e_req = 1'b1; e_we = mw; e_addr = a; e_wdata = wd;
            for (int i = 0; i < nwait; i++) begin
                mem_ack_i   = !to && (i >= k);
                mem_rdata_i = (!to && i == k) ? rdat : BG;
                edge_wb(1'b1, 32'h0);
            end
            e_req   = 1'b0;
            e_stall = 1'b0;
            if (to) e_err = 1'b1;
            mem_ack_i   = !to && (hold > 1);
            mem_rdata_i = BG;
            ack_tail    = (!to && hold > 2) ? hold - 2 : 0;
            edge_wb(1'b0, to ? 32'h0 : rdat);
        end
    endtask

    task automatic nop();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0);
    endtask

    initial begin
        int s0, r0, ra;
        RegWrite_i = 0; MemtoReg_i = 0; Memory_write_i = 0; Memory_read_i = 0;
        Data1_i = 0; mux7_output_data_i = 0; RDaddr_i = 0;
        mem_ack_i = 0; mem_rdata_i = BG;
        e_stall = 0; e_req = 0; e_we = 0; e_rw = 0; e_m2r = 0; e_err = 0;
        e_addr = 0; e_wdata = 0; e_rdata = 0; e_alu = 0; e_rd = 0;

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset stall_o", {31'b0, stall_o}, 32'h0);
        chk("reset mem_req_o", {31'b0, mem_req_o}, 32'h0);
        chk("reset RegWrite_o", {31'b0, RegWrite_o}, 32'h0);
        chk("reset ALUResult_o", ALUResult_o, 32'h0);
        chk("reset err_o", {31'b0, err_o}, 32'h0);
        rst_i  = 1'b1;
        chk_en = 1'b1;

        // ALU op: one-cycle stage
        issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5, 0, 0, 32'h0);
        chk("alu RegWrite_o", {31'b0, RegWrite_o}, 32'h1);
        chk("alu ALUResult_o", ALUResult_o, 32'h10);
        chk("alu RDaddr_o", {27'b0, RDaddr_o}, 32'd5);

        // Load, ack 3 cycles after request
        s0 = stall_total;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd9, 3, 1, 32'hDEAD_BEEF);
        chk("load stall cycles", stall_total - s0, 32'd5);
        chk("load ReadData_o", ReadData_o, 32'hDEAD_BEEF);
        chk("load MemtoReg_o", {31'b0, MemtoReg_o}, 32'h1);

        // Store with ack held for 4 cycles
        r0 = req_rises;
        issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h1234, 5'd0, 1, 4, BG);
        chk("store RegWrite_o", {31'b0, RegWrite_o}, 32'h0);
        chk("store mem_we_o", {31'b0, mem_we_o}, 32'h1);
        chk("store mem_wdata_o", mem_wdata_o, 32'h1234);
        nop();
        nop();
        chk("store request count", req_rises - r0, 32'd1);

        // Both read and write set: a write
        issue(1'b0, 1'b0, 1'b1, 1'b1, 32'h90, 32'h55, 5'd0, 0, 1, BG);

        // Back-to-back loads, zero ack latency
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd1, 0, 1, 32'h1111_1111);
        ra = last_rise;
        chk("b2b first ReadData_o", ReadData_o, 32'h1111_1111);
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h0, 5'd2, 0, 1, 32'h2222_2222);
        chk("b2b second ReadData_o", ReadData_o, 32'h2222_2222);
        chk("b2b request spacing", last_rise - ra, 32'd3);

        // Dead memory: timeout
        s0 = stall_total;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd7, TO, 0, 32'hDEAD_BEEF);
        chk("timeout stall cycles", stall_total - s0, 32'd9);
        chk("timeout err_o", {31'b0, err_o}, 32'h1);
        chk("timeout ReadData_o", ReadData_o, 32'h0);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h33, 32'h0, 5'd3, 0, 0, 32'h0);
        chk("resume ALUResult_o", ALUResult_o, 32'h33);

        // Reset during WAIT
        RegWrite_i = 1; MemtoReg_i = 1; Memory_write_i = 0; Memory_read_i = 1;
        Data1_i = 32'h300; mux7_output_data_i = 32'h0; RDaddr_i = 5'd4;
        mem_ack_i = 0; mem_rdata_i = BG;
        e_stall = 1'b1;
        edge_wb(1'b1, 32'h0);
        e_req = 1'b1; e_we = 1'b0; e_addr = 32'h300; e_wdata = 32'h0;
        edge_wb(1'b1, 32'h0);
        #1;
        rst_i = 1'b0;
        e_stall = 0; e_req = 0; e_rw = 0; e_m2r = 0; e_err = 0;
        e_rdata = 0; e_alu = 0; e_rd = 0;
        #1;
        chk("abort mem_req_o", {31'b0, mem_req_o}, 32'h0);
        chk("abort stall_o", {31'b0, stall_o}, 32'h0);
        chk("abort err_o", {31'b0, err_o}, 32'h0);
        chk("abort mem_addr_o", mem_addr_o, 32'h0);
        @(posedge clk_i);
        #1;
        Memory_read_i = 0; RegWrite_i = 0; MemtoReg_i = 0;
        rst_i = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h66, 32'h0, 5'd6, 0, 0, 32'h0);
        chk("post-reset RDaddr_o", {27'b0, RDaddr_o}, 32'd6);

        @(posedge clk_i);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
